// File: rtl/simple_ps_pkg.sv
// -----------------------------------------------------------------------------
// simple_ps_pkg
// Shared definitions for the simple processor phase logic.
//   - Phase index constants for the five pipeline phases
//   - Error code used when the strobe bus is not one-hot
//   - State enumeration of the receive-side phase decoder
//   - next_phase(): the in-order successor of a phase index (4 wraps to 0)
// -----------------------------------------------------------------------------
package simple_ps_pkg;

    localparam int NUM_PHASES = 5;

    localparam logic [2:0] PH_FETCH  = 3'd0;
    localparam logic [2:0] PH_DECODE = 3'd1;
    localparam logic [2:0] PH_READ   = 3'd2;
    localparam logic [2:0] PH_EXEC   = 3'd3;
    localparam logic [2:0] PH_WB     = 3'd4;

    localparam logic [2:0] ERR_MULTIHOT = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_ERROR  = 2'd3
    } phase_dec_state_t;

    function automatic logic [2:0] next_phase(input logic [2:0] p);
        return (p == PH_WB) ? PH_FETCH : p + 3'd1;
    endfunction

endpackage

// File: rtl/phase_decoder_onehot5_decode.sv
// -----------------------------------------------------------------------------
// onehot5_decode
// Combinational classifier for the 5-bit phase strobe bus.
// Ports:
//   phase_bus  in  [4:0]  strobe bus, bit k = phase k
//   valid      out        exactly one bit set
//   multi      out        two or more bits set
//   idx        out  [2:0] index of the set bit (meaningful only when valid)
// -----------------------------------------------------------------------------
module onehot5_decode (
    input  logic [4:0] phase_bus,
    output logic       valid,
    output logic       multi,
    output logic [2:0] idx
);

    logic [2:0] w_ones;

    always_comb begin
        w_ones = 3'd0;
        idx    = 3'd0;
        for (int k = 0; k < 5; k++) begin
            w_ones = w_ones + {2'b00, phase_bus[k]};
            if (phase_bus[k]) begin
                idx = 3'(k);
            end
        end
        valid = (w_ones == 3'd1);
        multi = (w_ones >= 3'd2);
    end

endmodule

// File: rtl/phase_decoder.sv
// -----------------------------------------------------------------------------
// phase_decoder
// Receive side of the processor phase controller. Checks that one-hot phase
// strobes arrive in order 0->1->2->3->4->0, turns each accepted strobe into a
// registered one-cycle stage enable, counts retired instructions, handles the
// halt/resume handshake and latches sequencing errors.
// Ports:
//   clock        in          system clock, rising edge
//   reset_n      in          asynchronous active-low reset
//   phase_bus    in  [4:0]   one-hot phase strobe, all-zero = no strobe
//   halt_req     in          level request to halt at end of instruction
//   resume       in          pulse, leave HALTED
//   clear_err    in          pulse, leave ERROR
//   stage_en     out [4:0]   one-cycle enable per accepted strobe
//   phase_out    out [2:0]   last accepted phase index
//   instr_done   out         one-cycle pulse on accepted phase 4
//   instr_count  out [CNT_W] retired instructions, wrapping
//   halted       out         high while HALTED
//   seq_error    out         high while ERROR
//   err_phase    out [2:0]   offending phase, 7 = not one-hot
//   dbg_state    out         current FSM state (observation only)
// Handshake: halt_req is a level sampled every rising edge in IDLE/RUN;
// resume and clear_err are single-cycle pulses acted on only in HALTED and
// ERROR respectively, and they take priority over any strobe in that cycle.
// -----------------------------------------------------------------------------
import simple_ps_pkg::*;

module phase_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [4:0]       phase_bus,
    input  logic             halt_req,
    input  logic             resume,
    input  logic             clear_err,
    output logic [4:0]       stage_en,
    output logic [2:0]       phase_out,
    output logic             instr_done,
    output logic [CNT_W-1:0] instr_count,
    output logic             halted,
    output logic             seq_error,
    output logic [2:0]       err_phase,
    output phase_dec_state_t dbg_state
);

    phase_dec_state_t r_state;
    logic             r_halt_pending;

    logic       w_valid;
    logic       w_multi;
    logic [2:0] w_idx;
    logic [2:0] w_expected;

    onehot5_decode u_decode (
        .phase_bus (phase_bus),
        .valid     (w_valid),
        .multi     (w_multi),
        .idx       (w_idx)
    );

    assign w_expected = next_phase(phase_out);
    assign dbg_state  = r_state;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= ST_IDLE;
            r_halt_pending <= 1'b0;
            stage_en       <= 5'd0;
            phase_out      <= PH_FETCH;
            instr_done     <= 1'b0;
            instr_count    <= '0;
            halted         <= 1'b0;
            seq_error      <= 1'b0;
            err_phase      <= 3'd0;
        end else begin
            // Pulsed outputs default low every cycle.
            stage_en   <= 5'd0;
            instr_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // A halt latched earlier takes effect before any new
                    // instruction can start.
                    if (r_halt_pending) begin
                        r_state        <= ST_HALTED;
                        r_halt_pending <= 1'b0;
                        halted         <= 1'b1;
                    end else begin
                        // Only phase 0 resynchronises; anything else is dropped
                        // silently.
                        if (w_valid && (w_idx == PH_FETCH)) begin
                            stage_en  <= phase_bus;
                            phase_out <= w_idx;
                            r_state   <= ST_RUN;
                        end
                        if (halt_req) begin
                            r_halt_pending <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    if (w_valid && (w_idx == w_expected)) begin
                        stage_en  <= phase_bus;
                        phase_out <= w_idx;
                        if (w_idx == PH_WB) begin
                            instr_done  <= 1'b1;
                            instr_count <= instr_count + CNT_W'(1);
                            // Instruction boundary: honour a latched or
                            // same-cycle halt request.
                            if (r_halt_pending || halt_req) begin
                                r_state        <= ST_HALTED;
                                r_halt_pending <= 1'b0;
                                halted         <= 1'b1;
                            end
                        end else if (halt_req) begin
                            r_halt_pending <= 1'b1;
                        end
                    end else if (w_valid || w_multi) begin
                        // Out-of-order or multi-hot strobe; error beats halt.
                        r_state        <= ST_ERROR;
                        seq_error      <= 1'b1;
                        err_phase      <= w_multi ? ERR_MULTIHOT : w_idx;
                        r_halt_pending <= 1'b0;
                    end else if (halt_req) begin
                        r_halt_pending <= 1'b1;
                    end
                end

                ST_HALTED: begin
                    if (resume) begin
                        r_state <= ST_IDLE;
                        halted  <= 1'b0;
                    end
                end

                ST_ERROR: begin
                    if (clear_err) begin
                        r_state   <= ST_IDLE;
                        seq_error <= 1'b0;
                        err_phase <= 3'd0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
